// File: rtl/hfrv_trace_buffer.sv
// Instruction-trace capture buffer: circular {pc, instr} history, trigger freeze, oldest-first drain.
// Optional TRACE_TIMESTAMP_EN macro adds a 32-bit cycle timestamp per sample and the rd_ts port.
module hfrv_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int POST_TRIG = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               cap_valid,
  input  logic [PC_W-1:0]    cap_pc,
  input  logic [INSTR_W-1:0] cap_instr,
  input  logic               trig,
  output logic               busy,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic               rd_trig,
  output logic               rd_last
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]        rd_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t             state;
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [AW-1:0]      wp, rp, trig_idx, post_cnt;
  logic [AW:0]        count, rem;

  logic               cap_en;
  logic [AW-1:0]      wp_inc, rp_start;
  logic [AW:0]        count_inc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cap_en    = cap_valid && (state == ARMED || state == POST);
    wp_inc    = wp + 1'b1;
    count_inc = (count == FULL) ? count : count + 1'b1;
    // Oldest entry of the frozen history, using the values the final write produces.
    rp_start  = wp_inc - count_inc[AW-1:0];
  end

  // NOTE: history storage has no reset; it is unobservable until rewritten, and a reset-free array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      pc_mem[wp]    <= cap_pc;
      instr_mem[wp] <= cap_instr;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (cap_en) ts_mem[wp] <= ts_cnt;
  end

  always_comb begin
    rd_ts = rd_valid ? ts_mem[rp] : '0;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      wp       <= '0;
      rp       <= '0;
      rem      <= '0;
      post_cnt <= '0;
      trig_idx <= '0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state <= ARMED;
            count <= '0;
            wp    <= '0;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          if (cap_valid) begin
            wp    <= wp_inc;
            count <= count_inc;
            if (trig) begin
              trig_idx <= wp;
              post_cnt <= AW'(POST_TRIG);
              if (POST_TRIG == 0) begin
                state    <= DONE;
                busy     <= 1'b0;
                rd_valid <= 1'b1;
                rp       <= rp_start;
                rem      <= count_inc;
              end else begin
                state <= POST;
              end
            end
          end
        end
        POST: begin
          if (cap_valid) begin
            wp       <= wp_inc;
            count    <= count_inc;
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == AW'(1)) begin
              state    <= DONE;
              busy     <= 1'b0;
              rd_valid <= 1'b1;
              rp       <= rp_start;
              rem      <= count_inc;
            end
          end
        end
        DONE: begin
          if (rd_ready) begin
            rp  <= rp + 1'b1;
            rem <= rem - 1'b1;
            if (rem == (AW+1)'(1)) begin
              state    <= IDLE;
              rd_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Readout fields are driven only while an entry is offered, so they read zero otherwise.
  always_comb begin
    rd_pc    = rd_valid ? pc_mem[rp]    : '0;
    rd_instr = rd_valid ? instr_mem[rp] : '0;
    rd_trig  = rd_valid && (rp == trig_idx);
    rd_last  = rd_valid && (rem == (AW+1)'(1));
  end

endmodule

// File: tb/tb_hfrv_trace_buffer.sv
// Directed bench for hfrv_trace_buffer: DEPTH=8/POST_TRIG=3 main instance plus a POST_TRIG=0 instance.
// Timestamp checks are compiled in when TRACE_TIMESTAMP_EN is defined.
module tb_hfrv_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm, arm0;
  logic        cap_valid;
  logic [31:0] cap_pc, cap_instr;
  logic        trig;
  logic        rd_ready, rd_ready0;

  logic        busy, rd_valid, rd_trig, rd_last;
  logic [31:0] rd_pc, rd_instr;
  logic        busy0, rd_valid0, rd_trig0, rd_last0;
  logic [31:0] rd_pc0, rd_instr0;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] rd_ts, rd_ts0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hfrv_trace_buffer #(.DEPTH(8), .PC_W(32), .INSTR_W(32), .POST_TRIG(3)) dut (
    .clk(clk), .reset(reset), .arm(arm), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_instr(cap_instr), .trig(trig), .busy(busy), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_trig(rd_trig),
    .rd_last(rd_last)
`ifdef TRACE_TIMESTAMP_EN
    , .rd_ts(rd_ts)
`endif
  );

  hfrv_trace_buffer #(.DEPTH(8), .PC_W(32), .INSTR_W(32), .POST_TRIG(0)) dut0 (
    .clk(clk), .reset(reset), .arm(arm0), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_instr(cap_instr), .trig(trig), .busy(busy0), .rd_valid(rd_valid0),
    .rd_ready(rd_ready0), .rd_pc(rd_pc0), .rd_instr(rd_instr0), .rd_trig(rd_trig0),
    .rd_last(rd_last0)
`ifdef TRACE_TIMESTAMP_EN
    , .rd_ts(rd_ts0)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h0013_5A00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic t);
    cap_valid = 1'b1;
    cap_pc    = pc;
    cap_instr = instr_of(pc);
    trig      = t;
    tick();
    cap_valid = 1'b0;
    trig      = 1'b0;
  endtask

  // Drain n entries at full rate, expecting pc = base + 4*i and the trigger at index trig_i.
  task automatic drain(input string tag, input logic [31:0] base, input int n, input int trig_i);
    logic [31:0] pc;
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      pc = base + 32'(4 * i);
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_pc"},    rd_pc, pc);
      check({tag, "_instr"}, rd_instr, instr_of(pc));
      check({tag, "_trig"},  32'(rd_trig), 32'(i == trig_i));
      check({tag, "_last"},  32'(rd_last), 32'(i == n - 1));
      tick();
    end
    rd_ready = 1'b0;
    check({tag, "_valid_after"}, 32'(rd_valid), 32'd0);
    check({tag, "_busy_after"},  32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; arm0 = 1'b0; cap_valid = 1'b0; cap_pc = '0;
    cap_instr = '0; trig = 1'b0; rd_ready = 1'b0; rd_ready0 = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_busy",     32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_trig",  32'(rd_trig), 32'd0);
    check("rst_rd_last",  32'(rd_last), 32'd0);
    check("rst_rd_pc",    rd_pc, 32'd0);
    check("rst_rd_instr", rd_instr, 32'd0);
`ifdef TRACE_TIMESTAMP_EN
    check("rst_rd_ts",    rd_ts, 32'd0);
`endif

    // Trigger sample while idle is ignored.
    push(32'h0000_0F00, 1'b1);
    check("idle_trig_busy",  32'(busy), 32'd0);
    check("idle_trig_valid", 32'(rd_valid), 32'd0);

    // Basic capture, with a stray trig (no cap_valid) and an arm during POST.
    do_arm();
    check("arm_busy", 32'(busy), 32'd1);
    push(32'h100, 1'b0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("stray_trig_busy", 32'(busy), 32'd1);
    push(32'h104, 1'b0);
    push(32'h108, 1'b1);
    check("post_busy", 32'(busy), 32'd1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("post_arm_busy", 32'(busy), 32'd1);
    push(32'h10C, 1'b0);
    push(32'h110, 1'b0);
    check("post_not_done", 32'(rd_valid), 32'd0);
    push(32'h114, 1'b0);
    check("done_busy", 32'(busy), 32'd0);
    drain("basic", 32'h100, 6, 2);

    // Wrap: 20 samples into 8 slots, trigger on the 17th.
    do_arm();
    for (int k = 0; k < 20; k++) push(32'h1000 + 32'(4 * k), k == 16);
    for (int c = 0; c < 4; c++) begin
      check("bp_valid", 32'(rd_valid), 32'd1);
      check("bp_pc",    rd_pc, 32'h1030);
      check("bp_instr", rd_instr, instr_of(32'h1030));
      tick();
    end
    drain("wrap", 32'h1030, 8, 4);

    // Reset two samples into POST.
    do_arm();
    push(32'h2000, 1'b1);
    push(32'h2004, 1'b0);
    push(32'h2008, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy",  32'(busy), 32'd0);
    check("midrst_valid", 32'(rd_valid), 32'd0);
    push(32'h200C, 1'b0);
    check("midrst_valid2", 32'(rd_valid), 32'd0);

    // POST_TRIG=0 instance: one triggering sample gives a single trig+last entry.
    arm0 = 1'b1;
    tick();
    arm0 = 1'b0;
    check("pt0_busy", 32'(busy0), 32'd1);
    push(32'h3000, 1'b1);
    check("pt0_valid", 32'(rd_valid0), 32'd1);
    check("pt0_pc",    rd_pc0, 32'h3000);
    check("pt0_trig",  32'(rd_trig0), 32'd1);
    check("pt0_last",  32'(rd_last0), 32'd1);
    check("pt0_main_idle", 32'(busy), 32'd0);
    rd_ready0 = 1'b1;
    tick();
    rd_ready0 = 1'b0;
    check("pt0_valid_after", 32'(rd_valid0), 32'd0);

`ifdef TRACE_TIMESTAMP_EN
    begin
      logic [31:0] prev;
      do_arm();
      for (int k = 0; k < 4; k++) begin
        push(32'h4000 + 32'(4 * k), k == 0);
        if (k < 3) begin
          tick();
          tick();
        end
      end
      rd_ready = 1'b1;
      prev = rd_ts;
      tick();
      for (int k = 1; k < 4; k++) begin
        check("ts_delta", rd_ts - prev, 32'd3);
        prev = rd_ts;
        tick();
      end
      rd_ready = 1'b0;
      check("ts_done", 32'(rd_valid), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
